// File: rtl/imm_pkg.sv
// imm_pkg: shared definitions for the pipelined immediate generator.
//   - EXTOP_* encodings of the immediate-format selector
//   - extop_t: 3-bit format selector type
//   - IMM_DEPTH: number of entries in the elastic output buffer
// The {imm, tag, illegal} entry struct depends on XLEN/TAG_W, so it is
// declared inside the module that owns those parameters.
package imm_pkg;

  typedef logic [2:0] extop_t;

  localparam extop_t EXTOP_I     = 3'b000;
  localparam extop_t EXTOP_S     = 3'b001;
  localparam extop_t EXTOP_B     = 3'b010;
  localparam extop_t EXTOP_U     = 3'b011;
  localparam extop_t EXTOP_J     = 3'b100;
  localparam extop_t EXTOP_ZIMM  = 3'b101;
  localparam extop_t EXTOP_SHAMT = 3'b110;
  localparam extop_t EXTOP_RSVD  = 3'b111;

  localparam int unsigned IMM_DEPTH = 2;

endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational immediate extraction and extension.
// Ports:
//   inst    in  32    raw instruction (bits [6:0] are not used)
//   extop   in  3     immediate format selector
//   imm     out XLEN  extended immediate (0 when illegal)
//   illegal out 1     format/encoding not valid for this XLEN
// Every format is first built at 64 bits and then truncated to XLEN, so one
// expression serves both the 32- and the 64-bit configuration.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  extop_t          extop,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [63:0] imm64_s;
  logic        illegal_s;
  logic        unused_inst_bits_s;

  // The opcode field plays no part in immediate extraction.
  assign unused_inst_bits_s = ^inst[6:0];

  // Format decode at full 64-bit width.
  always_comb begin
    imm64_s   = 64'd0;
    illegal_s = 1'b0;
    case (extop)
      EXTOP_I:     imm64_s = {{52{inst[31]}}, inst[31:20]};
      EXTOP_S:     imm64_s = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      EXTOP_B:     imm64_s = {{51{inst[31]}}, inst[31], inst[7], inst[30:25],
                              inst[11:8], 1'b0};
      EXTOP_U:     imm64_s = {{32{inst[31]}}, inst[31:12], 12'd0};
      EXTOP_J:     imm64_s = {{43{inst[31]}}, inst[31], inst[19:12], inst[20],
                              inst[30:21], 1'b0};
      EXTOP_ZIMM:  imm64_s = {59'd0, inst[19:15]};
      EXTOP_SHAMT: begin
        if (XLEN == 64) begin
          imm64_s = {58'd0, inst[25:20]};
        end else begin
          imm64_s = {59'd0, inst[24:20]};
          // A 6-bit shift amount cannot be encoded on a 32-bit datapath.
          if (inst[25]) begin
            illegal_s = 1'b1;
          end else begin
            illegal_s = 1'b0;
          end
        end
      end
      default:     illegal_s = 1'b1;
    endcase
  end

  assign illegal = illegal_s;
  assign imm     = illegal_s ? {XLEN{1'b0}} : imm64_s[XLEN-1:0];

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate generator with a 2-entry elastic buffer.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   flush                drop buffered entries and the same-cycle input beat
//   in_valid/in_ready    input handshake (in_ready has no path from out_ready)
//   in_inst, in_extop    raw instruction and immediate format
//   in_tag               sideband carried unchanged with the immediate
//   out_valid/out_ready  output handshake for the head entry
//   out_imm, out_tag     head entry contents (0 when out_valid=0)
//   out_illegal          head entry format/encoding was illegal
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  extop_t           in_extop,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  entry_t          mem_q [IMM_DEPTH];
  entry_t          mem_d [IMM_DEPTH];
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;

  logic [XLEN-1:0] dec_imm_s;
  logic            dec_illegal_s;
  entry_t          new_entry_s;
  entry_t          head_s;
  logic            push_s;
  logic            pop_s;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst    (in_inst),
    .extop   (in_extop),
    .imm     (dec_imm_s),
    .illegal (dec_illegal_s)
  );

  assign new_entry_s = '{imm: dec_imm_s, tag: in_tag, illegal: dec_illegal_s};

  assign in_ready  = rst_n & (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push_s    = in_valid & in_ready & ~flush;
  assign pop_s     = out_valid & out_ready & ~flush;

  // Buffer next-state: flush wins over any push/pop in the same cycle.
  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = new_entry_s;
        wr_ptr_d        = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Buffer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Stale data left in a popped slot is masked whenever the buffer is empty.
  assign head_s      = mem_q[rd_ptr_q];
  assign out_imm     = out_valid ? head_s.imm : {XLEN{1'b0}};
  assign out_tag     = out_valid ? head_s.tag : {TAG_W{1'b0}};
  assign out_illegal = out_valid ? head_s.illegal : 1'b0;

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the decode stage. It accepts a raw 32-bit instruction plus an immediate-format selector through a valid/ready handshake. It produces the sign- or zero-extended immediate at XLEN width through a 2-entry elastic buffer. Over the combinational extender it adds XLEN=64 support, CSR zimm and shamt formats, an illegal flag, a flush, and backpressure.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64.
TAG_W, 32, width of the sideband tag (PC or ROB id) carried alongside each immediate.

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
flush  in  1  drop all buffered entries and any same-cycle input beat
in_valid  in  1  input beat valid
in_ready  out  1  buffer can accept a beat
in_inst  in  32  raw instruction; bits [6:0] ignored
in_extop  in  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 ZIMM, 110 SHAMT, 111 reserved
in_tag  in  TAG_W  sideband, passed through unchanged
out_valid  out  1  head entry valid
out_ready  in  1  consumer accepts head
out_imm  out  XLEN  extended immediate
out_tag  out  TAG_W  tag of head entry
out_illegal  out  1  format or encoding illegal for this XLEN

Behaviour:
- Decode (combinational, on input side). Signed formats are sign-extended to XLEN from the top bit shown:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}
  - U: {inst[31:12], 12'b0}; sign-extended from bit 31 when XLEN=64
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}
  - ZIMM: zero-extend inst[19:15]
  - SHAMT: zero-extend inst[24:20] (XLEN=32) or inst[25:20] (XLEN=64)
- Illegal cases: extop=111, or SHAMT with XLEN=32 and inst[25]=1. Either sets illegal=1 and forces imm to 0. The entry is still queued.
- Storage: 2 entries of {imm, tag, illegal}; 1-bit wr_ptr and rd_ptr; count register 0..2.
- Handshake:
  - Push when in_valid & in_ready & !flush. Pop when out_valid & out_ready & !flush.
  - in_ready = rst_n & (count != 2); no combinational path from out_ready.
  - out_valid = (count != 0).
  - Simultaneous push and pop at count 1: count stays 1, pointers both advance.
- Latency: a beat accepted at edge N is visible on out_* after edge N; one beat per cycle sustained when out_ready=1.
- When out_valid=0, out_imm, out_tag and out_illegal are driven 0.
- Flush: highest priority after reset. At the next edge count=0 and ptrs=0; a same-cycle push or pop is ignored.
- Reset (rst_n=0 at edge): count=0, ptrs=0, all storage=0. out_valid=0, out_imm=0, out_tag=0, out_illegal=0. in_ready=0 while rst_n=0. A reset mid-stream discards all entries.
- Ordering: strict FIFO; wrap-around of 1-bit pointers has no special case.

Decomposition:
- Package imm_pkg: EXTOP_* localparams for the eight encodings, an extop typedef (logic [2:0]), and an entry struct {imm, tag, illegal} parametrised via XLEN/TAG_W at use site.
- Sub-module imm_decode: purely combinational decode (inst, extop -> imm, illegal), parametrised by XLEN. The top level holds only the buffer and handshake.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_imm=0; first cycle after release in_ready=1.
- Formats, XLEN=32, out_ready=1:
  - I 0xFFF00093 -> 0xFFFFFFFF
  - B 0xFE000EE3 -> 0xFFFFFFFC
  - J 0x800000EF -> 0xFFF00000
  - U 0x800000B7 -> 0x80000000
  - ZIMM with inst[19:15]=31 -> 0x0000001F
  - Each output appears one cycle after acceptance.
- XLEN=64: U 0x800000B7 -> 0xFFFFFFFF80000000; SHAMT 0x03F01013 -> 0x3F, illegal=0. XLEN=32: SHAMT 0x02001013 -> imm=0, illegal=1; extop=111 -> imm=0, illegal=1.
- Backpressure: out_ready=0, present beats A,B,C (tags 1,2,3) -> A,B accepted, in_ready=0 with C held; raise out_ready -> tags 1,2,3 emerge in order, no loss or duplication.
- Flush: count=2 and in_valid=1 with flush=1 -> next cycle out_valid=0, in_ready=1, and the flushed input beat never appears.
- Throughput: out_ready=1, 8 back-to-back beats (tags 0..7) -> out_valid high 8 consecutive cycles, tags 0..7 in order, 1-cycle latency.
